// File: rtl/btn_evt_pkg.sv
// Shared state encoding for the button event channels.
// The ST_* names are also used by the menu FSM debug view.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2,
        ST_RSVD = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_event_gen_channel.sv
// Legacy file name retained for build scripts; holds no logic.
// The per-button channel is implemented in btn_event_channel.sv.
package button_event_gen_channel_pkg;
endpackage

// File: rtl/btn_event_channel.sv
// One button channel: edge register, press/held/long FSM, hold counter.
// Ports: clk, rst_n, i_en, i_level in; o_press/o_release/o_long/o_repeat/o_held out.
module btn_event_channel
    import btn_evt_pkg::*;
#(
    parameter int CNT_W      = 28,
    parameter int LONG_CNT   = 100_000_000,
    parameter int REPEAT_CNT = 20_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  =
        CNT_W'((REPEAT_CNT == 0) ? 0 : REPEAT_CNT - 1);

    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prev;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic             w_rise;

    assign w_rise = i_level & ~r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_prev    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_prev    <= i_level;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            if (!i_en) begin
                // Aborted presses end silently, no release event.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_held  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_state <= ST_HELD;
                            r_press <= 1'b1;
                            r_held  <= 1'b1;
                        end
                        r_cnt <= '0;
                    end
                    ST_HELD: begin
                        // Release wins over a coinciding long event.
                        if (!i_level) begin
                            r_state   <= ST_IDLE;
                            r_release <= 1'b1;
                            r_held    <= 1'b0;
                            r_cnt     <= '0;
                        end else if (r_cnt == LONG_LAST) begin
                            r_state <= ST_LONG;
                            r_long  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_LONG: begin
                        if (!i_level) begin
                            r_state   <= ST_IDLE;
                            r_release <= 1'b1;
                            r_held    <= 1'b0;
                            r_cnt     <= '0;
                        end else if (REPEAT_CNT != 0) begin
                            if (r_cnt == REP_LAST) begin
                                r_repeat <= 1'b1;
                                r_cnt    <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_held    = r_held;

endmodule

// File: rtl/button_event_gen.sv
// Turns debounced button levels into press/release/long/repeat pulses.
// Ports: clk, rst_n, en, btn_level in; *_pulse and held out (NUM_BTN each).
module button_event_gen
    import btn_evt_pkg::*;
#(
    parameter int NUM_BTN    = 5,
    parameter int CNT_W      = 28,
    parameter int LONG_CNT   = 100_000_000,
    parameter int REPEAT_CNT = 20_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse,
    output logic [NUM_BTN-1:0] held
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_event_channel #(
            .CNT_W      (CNT_W),
            .LONG_CNT   (LONG_CNT),
            .REPEAT_CNT (REPEAT_CNT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (en),
            .i_level   (btn_level[g]),
            .o_press   (press_pulse[g]),
            .o_release (release_pulse[g]),
            .o_long    (long_pulse[g]),
            .o_repeat  (repeat_pulse[g]),
            .o_held    (held[g])
        );
    end

endmodule
